// File: rtl/param_mem_ctrl_pkg.sv
// rtl/param_mem_ctrl_pkg.sv - state/opcode encodings and instruction field helpers
package param_mem_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_READ   = 4'd3,
        ST_EXEC   = 4'd4,
        ST_WB     = 4'd5,
        ST_HALT   = 4'd6
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction words are passed zero-extended to 32 bits so one helper serves any IW.
    function automatic logic [3:0] f_opcode(input logic [31:0] word, input int iw);
        return word[iw-4 +: 4];
    endfunction

    // pos 0 = src2 (LSBs), 1 = src1, 2 = dest
    function automatic logic [7:0] f_field(input logic [31:0] word, input int raw, input int pos);
        return 8'((word >> (pos * raw)) & ((32'd1 << raw) - 32'd1));
    endfunction

endpackage

// File: rtl/mem_ctrl_alu.sv
// rtl/mem_ctrl_alu.sv - combinational ALU for opcodes 0-7 and MOV
module mem_ctrl_alu
    import param_mem_ctrl_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] opa1,
    input  logic [DW-1:0] opa2,
    input  logic [3:0]    opcode,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [DW:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide   = {1'b0, opa1} + {1'b0, opa2};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            // Extra top bit of the wrapped difference is the borrow.
            OP_SUB: begin
                wide   = {1'b0, opa1} - {1'b0, opa2};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            OP_AND: result = opa1 & opa2;
            OP_OR:  result = opa1 | opa2;
            OP_XOR: result = opa1 ^ opa2;
            OP_NOT: result = ~opa1;
            OP_SHL: begin
                result = {opa1[DW-2:0], 1'b0};
                carry  = opa1[DW-1];
            end
            OP_SHR: begin
                result = {1'b0, opa1[DW-1:1]};
                carry  = opa1[0];
            end
            OP_MOV: result = opa1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/param_mem_controller.sv
// rtl/param_mem_controller.sv - multi-cycle fetch/decode/read/exec/writeback controller
module param_mem_controller
    import param_mem_ctrl_pkg::*;
#(
    parameter  int DW         = 16,
    parameter  int RF_DEPTH   = 16,
    parameter  int IMEM_DEPTH = 32,
    localparam int RAW        = $clog2(RF_DEPTH),
    localparam int PC_W       = $clog2(IMEM_DEPTH),
    localparam int IW         = 4 + 3 * RAW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            S,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_data,
    output logic [3:0]      curr,
    output logic [PC_W-1:0] pc,
    output logic [IW-1:0]   temp,
    output logic [3:0]      opcode,
    output logic [RAW-1:0]  dest,
    output logic [RAW-1:0]  src1,
    output logic [RAW-1:0]  src2,
    output logic [DW-1:0]   opa1,
    output logic [DW-1:0]   opa2,
    output logic [DW-1:0]   alutemp,
    output logic            zf,
    output logic            cf,
    output logic            halted
);

    state_t          state, next_state;
    logic [DW-1:0]   regs [RF_DEPTH];
    logic [DW-1:0]   alu_result;
    logic            alu_carry;
    logic [DW-1:0]   exec_result;
    logic [2*RAW-1:0] imm;
    logic            br_taken;

    assign curr      = state;
    assign imem_addr = pc;
    assign imm       = {src1, src2};

    mem_ctrl_alu #(.DW(DW)) u_alu (
        .opa1   (opa1),
        .opa2   (opa2),
        .opcode (opcode),
        .result (alu_result),
        .carry  (alu_carry)
    );

    assign exec_result = (opcode == OP_LDI) ? DW'(imm) : alu_result;
    // Branches never write the register file, so reg[dest] is stable in WB.
    assign br_taken = (opcode == OP_JMP) || ((opcode == OP_BEQZ) && (regs[dest] == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        case (state)
            ST_IDLE:   if (S) next_state = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) next_state = ST_DECODE;
            end
            ST_DECODE: next_state = ST_READ;
            ST_READ:   next_state = ST_EXEC;
            ST_EXEC:   next_state = ST_WB;
            ST_WB: begin
                if (opcode == OP_HALT) next_state = ST_HALT;
                else if (S)            next_state = ST_FETCH;
                else                   next_state = ST_IDLE;
            end
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            temp    <= '0;
            opcode  <= '0;
            dest    <= '0;
            src1    <= '0;
            src2    <= '0;
            opa1    <= '0;
            opa2    <= '0;
            alutemp <= '0;
            zf      <= 1'b0;
            cf      <= 1'b0;
            halted  <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: if (imem_ack) temp <= imem_data;
                ST_DECODE: begin
                    opcode <= f_opcode(32'(temp), IW);
                    dest   <= RAW'(f_field(32'(temp), RAW, 2));
                    src1   <= RAW'(f_field(32'(temp), RAW, 1));
                    src2   <= RAW'(f_field(32'(temp), RAW, 0));
                end
                ST_READ: begin
                    opa1 <= regs[src1];
                    opa2 <= regs[src2];
                end
                ST_EXEC: begin
                    alutemp <= exec_result;
                    if (!opcode[3]) begin
                        zf <= (exec_result == '0);
                        cf <= alu_carry;
                    end
                end
                ST_WB: begin
                    if (opcode <= OP_MOV) regs[dest] <= alutemp;
                    if (opcode == OP_HALT) halted <= 1'b1;
                    else if (br_taken)     pc <= PC_W'(imm);
                    else                   pc <= pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/param_mem_controller.md
Name: param_mem_controller

Overview:
- Parametrised multi-cycle instruction controller: the next generation of the lab mem_controller.
- Fetches instructions over a req/ack instruction-memory port, decodes them, reads operands from an internal register file, executes on an internal ALU and writes results back.
- Generalised in data width, register count and program depth.
- Adds immediate loads, branches, HALT, status flags and start/stop pausing.

Parameters:
- DW, 16, data/register width in bits (≥8).
- RF_DEPTH, 16, number of registers (power of two); RAW = clog2(RF_DEPTH).
- IMEM_DEPTH, 32, instruction address space (power of two); PC_W = clog2(IMEM_DEPTH).
- IW (derived), 4+3*RAW, instruction width; fields are opcode[IW-1:IW-4], dest, src1, src2 (src2 is the LSBs).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- S  in  1  run enable (level).
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  fetch data valid.
- imem_data  in  IW  instruction word.
- curr  out  4  current state code.
- pc  out  PC_W  program counter.
- temp  out  IW  latched instruction.
- opcode  out  4  decoded opcode.
- dest  out  RAW  decoded field.
- src1  out  RAW  decoded field.
- src2  out  RAW  decoded field.
- opa1  out  DW  operand 1 = reg[src1].
- opa2  out  DW  operand 2 = reg[src2].
- alutemp  out  DW  registered ALU result.
- zf  out  1  zero flag.
- cf  out  1  carry/borrow flag.
- halted  out  1  HALT executed.

Behaviour:
- Reset (asynchronous, immediate, mid-operation included): curr=IDLE, and pc, temp, opcode, dest, src1, src2, opa1, opa2, alutemp, zf, cf, halted, imem_req and all registers are 0.
- State codes: IDLE=0, FETCH=1, DECODE=2, READ=3, EXEC=4, WB=5, HALT=6.
- IDLE: go to FETCH when S=1.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack=1 is sampled.
  - On the ack edge: temp<=imem_data, go to DECODE.
  - imem_req is high only in FETCH.
- DECODE: split temp into opcode/dest/src1/src2.
- READ: opa1<=reg[src1], opa2<=reg[src2].
- EXEC:
  - alutemp<=result, all arithmetic modulo 2^DW.
  - zf/cf update only for opcodes 0-7.
  - Opcodes:
    - 0 ADD: cf = carry out.
    - 1 SUB: opa1-opa2, cf = borrow.
    - 2 AND, 3 OR, 4 XOR: cf=0.
    - 5 NOT opa1: cf=0.
    - 6 SHL1: cf = msb shifted out.
    - 7 SHR1 (logical): cf = lsb shifted out.
    - 8 LDI: result = zero-extended {src1,src2}.
    - 9 MOV: result = opa1.
    - A BEQZ: taken if reg[dest]==0.
    - B JMP.
    - F HALT.
    - C-E: NOP.
  - zf = (result==0).
- WB:
  - Opcodes 0-9 write reg[dest]<=alutemp.
  - Next pc:
    - A taken / B: {src1,src2} truncated or zero-extended to PC_W.
    - Otherwise pc+1, wrapping IMEM_DEPTH-1 → 0.
  - F: halted<=1, go to HALT, pc unchanged.
  - Else: go to FETCH if S=1, IDLE if S=0 (pause; pc and registers preserved; resumes when S returns to 1).
- S=0 mid-instruction: the current instruction completes; S is sampled only in IDLE and WB.
- HALT: terminal until reset; imem_req=0; S ignored.
- Latency: 5 cycles per instruction with zero-wait ack (ack in the first FETCH cycle); +1 per ack wait cycle.
- Register write in WB and operand read in READ never overlap, so no forwarding is needed.

Decomposition:
- Package param_mem_ctrl_pkg: state encoding constants, opcode constants, field-extraction helper functions.
- One sub-module, mem_ctrl_alu (combinational, parametrised DW): opa1, opa2, opcode → result, carry.

Test Plan:
- Sequential ops: program LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2; HALT with zero-wait ack → alutemp=0x0008 at ADD WB, zf=0, halted=1 after 20 cycles, curr=6.
- Flags: SUB r4,r2,r1 (3-5) → alutemp=0xFFFE, cf=1, zf=0; then XOR r5,r1,r1 → zf=1, cf=0.
- Branch: BEQZ r5 target 0x1F with r5=0 → pc=0x1F; JMP 0x00 → pc=0; with r5=7 the BEQZ falls through to pc+1; pc=31 followed by a NOP wraps to 0.
- Handshake: ack delayed 3 cycles → imem_req and imem_addr stable throughout, instruction takes 8 cycles, temp updates only on the ack edge.
- Pause/reset: drop S during EXEC → instruction finishes, curr=0, pc=next; S=1 resumes. Assert reset mid-FETCH → imem_req=0 and all outputs 0 before the next clock edge.
- Params: DW=8, RF_DEPTH=8, IMEM_DEPTH=16 (IW=13) → SHL 0x81 gives 0x02 with cf=1; LDI immediate 6 bits wide.
